rx_frame_buffer: RTL and testbench

- Receive-side byte FIFO directly downstream of the rx FSM.
- Accepts payload bytes qualified by `brx_valid` and returns `brx_full` as backpressure. The FSM uses `brx_full` to gate `rx_axis_tready`.
- Stores each byte with its `tlast` flag and presents frames on an AXI-Stream master port in store-and-forward fashion.
- Falls back to cut-through when a single frame exceeds the buffer depth.

---
 rtl/rx_frame_buffer_if.sv | 28 ++
 rtl/rx_frame_buffer.sv | 87 ++++++++
 tb/tb_rx_frame_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_buffer_if.sv
// Bundle of the rx FSM write port, the AXI-Stream master port and the occupancy
// status of rx_frame_buffer. The buffer uses "master"; the surrounding logic uses "slave".
interface rx_frame_buffer_if #(
  parameter int DEPTH = 2048
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              brx_valid;
  logic [7:0]        rx_axis_tdata;
  logic              rx_axis_tlast;
  logic              brx_full;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   frame_count;

  modport master (
    input  brx_valid, rx_axis_tdata, rx_axis_tlast, m_axis_tready,
    output brx_full, m_axis_tdata, m_axis_tvalid, m_axis_tlast, level, frame_count
  );

  modport slave (
    output brx_valid, rx_axis_tdata, rx_axis_tlast, m_axis_tready,
    input  brx_full, m_axis_tdata, m_axis_tvalid, m_axis_tlast, level, frame_count
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// Receive-side byte FIFO: holds whole frames before forwarding them (store-and-forward),
// switching to cut-through only when a single frame is larger than the buffer.
module rx_frame_buffer #(
  parameter int DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  rx_frame_buffer_if.master bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W:0]   frame_count_q, frame_count_d;
  logic              full_q, full_d;
  logic              cut_q, cut_d;
  logic              wr_en, rd_en, wr_last, rd_last, tvalid;
  logic [8:0]        head;

  assign head    = mem[rd_ptr_q];
  assign tvalid  = (level_q != '0) && ((frame_count_q != '0) || full_q || cut_q);
  assign wr_en   = bus.brx_valid && !full_q;
  assign rd_en   = tvalid && bus.m_axis_tready;
  assign wr_last = wr_en && bus.rx_axis_tlast;
  assign rd_last = rd_en && head[8];

  always_comb begin
    wr_ptr_d      = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d      = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d       = level_q;
    frame_count_d = frame_count_q;
    cut_d         = cut_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + LVL_ONE;
    end else if (rd_en && !wr_en) begin
      level_d = level_q - LVL_ONE;
    end
    if (wr_last && !rd_last) begin
      frame_count_d = frame_count_q + LVL_ONE;
    end else if (rd_last && !wr_last) begin
      frame_count_d = frame_count_q - LVL_ONE;
    end
    // A full buffer with no complete frame can only drain by streaming the oversize frame out.
    if (rd_last) begin
      cut_d = 1'b0;
    end else if (full_q && (frame_count_q == '0)) begin
      cut_d = 1'b1;
    end
    full_d = (level_d == LVL_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      frame_count_q <= '0;
      full_q        <= 1'b0;
      cut_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      frame_count_q <= frame_count_d;
      full_q        <= full_d;
      cut_q         <= cut_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {bus.rx_axis_tlast, bus.rx_axis_tdata};
    end
  end

  assign bus.brx_full      = full_q;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = head[7:0];
  assign bus.m_axis_tlast  = head[8];
  assign bus.level         = level_q;
  assign bus.frame_count   = frame_count_q;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: a 2048-entry instance for normal frames and a
// 16-entry instance for full, oversize and simultaneous-event corner cases.
module tb_rx_frame_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rx_frame_buffer_if #(.DEPTH(2048)) busA ();
  rx_frame_buffer_if #(.DEPTH(16))   busB ();

  rx_frame_buffer #(.DEPTH(2048)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  rx_frame_buffer #(.DEPTH(16))   dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (busA.level !== 12'd0) begin errors++; $display("[TB] FAIL reset_level_a: got %0d want 0", busA.level); end
    checks++; if (busA.frame_count !== 12'd0) begin errors++; $display("[TB] FAIL reset_fc_a: got %0d want 0", busA.frame_count); end
    checks++; if (busA.brx_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_a: got %b want 0", busA.brx_full); end
    checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid_a: got %b want 0", busA.m_axis_tvalid); end
    checks++; if (busB.level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level_b: got %0d want 0", busB.level); end
    checks++; if (busB.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid_b: got %b want 0", busB.m_axis_tvalid); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_store_forward;
    busA.m_axis_tready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      busA.brx_valid = 1'b1;
      busA.rx_axis_tdata = 8'(i);
      busA.rx_axis_tlast = (i == 59);
      checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL sf_hold byte %0d: got tvalid %b want 0", i, busA.m_axis_tvalid); end
      tick;
    end
    busA.brx_valid = 1'b0;
    busA.rx_axis_tlast = 1'b0;
    for (int k = 0; k < 60; k++) begin
      checks++; if (busA.m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL sf_tvalid byte %0d: got %b want 1", k, busA.m_axis_tvalid); end
      checks++; if (busA.m_axis_tdata !== 8'(k)) begin errors++; $display("[TB] FAIL sf_data byte %0d: got %h want %h", k, busA.m_axis_tdata, 8'(k)); end
      checks++; if (busA.m_axis_tlast !== (k == 59)) begin errors++; $display("[TB] FAIL sf_last byte %0d: got %b want %b", k, busA.m_axis_tlast, (k == 59)); end
      checks++; if (busA.frame_count !== 12'd1) begin errors++; $display("[TB] FAIL sf_fc byte %0d: got %0d want 1", k, busA.frame_count); end
      tick;
    end
    checks++; if (busA.frame_count !== 12'd0) begin errors++; $display("[TB] FAIL sf_fc_end: got %0d want 0", busA.frame_count); end
    checks++; if (busA.level !== 12'd0) begin errors++; $display("[TB] FAIL sf_level_end: got %0d want 0", busA.level); end
    checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL sf_tvalid_end: got %b want 0", busA.m_axis_tvalid); end
    busA.m_axis_tready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int         rd_idx;
    int         peak;
    logic       stall;
    logic [7:0] held_d;
    logic       held_l;
    logic       exp_last;
    rd_idx = 0;
    peak = 0;
    stall = 1'b0;
    held_d = 8'h00;
    held_l = 1'b0;
    busA.m_axis_tready = 1'b0;
    fork
      begin
        for (int g = 0; g < 228; g++) begin
          busA.brx_valid = 1'b1;
          busA.rx_axis_tdata = 8'(g);
          busA.rx_axis_tlast = (g == 63) || (g == 163) || (g == 227);
          tick;
        end
        busA.brx_valid = 1'b0;
        busA.rx_axis_tlast = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && rd_idx < 228; c++) begin
          tick;
          if (int'(busA.frame_count) > peak) peak = int'(busA.frame_count);
          if (stall) begin
            checks++;
            if (busA.m_axis_tvalid !== 1'b1 || busA.m_axis_tdata !== held_d || busA.m_axis_tlast !== held_l) begin
              errors++;
              $display("[TB] FAIL b2b_stable: got v%b d%h l%b want v1 d%h l%b", busA.m_axis_tvalid, busA.m_axis_tdata, busA.m_axis_tlast, held_d, held_l);
            end
          end
          busA.m_axis_tready = (peak >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
          if (busA.m_axis_tvalid === 1'b1) begin
            if (busA.m_axis_tready) begin
              exp_last = (rd_idx == 63) || (rd_idx == 163) || (rd_idx == 227);
              checks++; if (busA.m_axis_tdata !== 8'(rd_idx)) begin errors++; $display("[TB] FAIL b2b_data idx %0d: got %h want %h", rd_idx, busA.m_axis_tdata, 8'(rd_idx)); end
              checks++; if (busA.m_axis_tlast !== exp_last) begin errors++; $display("[TB] FAIL b2b_last idx %0d: got %b want %b", rd_idx, busA.m_axis_tlast, exp_last); end
              rd_idx++;
              stall = 1'b0;
            end else begin
              stall = 1'b1;
              held_d = busA.m_axis_tdata;
              held_l = busA.m_axis_tlast;
            end
          end else begin
            stall = 1'b0;
          end
        end
      end
    join
    tick;
    busA.m_axis_tready = 1'b0;
    checks++; if (rd_idx != 228) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 228", rd_idx); end
    checks++; if (peak != 3) begin errors++; $display("[TB] FAIL b2b_peak_fc: got %0d want 3", peak); end
    checks++; if (busA.level !== 12'd0) begin errors++; $display("[TB] FAIL b2b_level_end: got %0d want 0", busA.level); end
    checks++; if (busA.frame_count !== 12'd0) begin errors++; $display("[TB] FAIL b2b_fc_end: got %0d want 0", busA.frame_count); end
  endtask

  task automatic test_full_backpressure;
    logic [7:0] exp_d;
    busB.m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      busB.brx_valid = 1'b1;
      busB.rx_axis_tdata = 8'hA0 + 8'(i);
      busB.rx_axis_tlast = (i == 7) || (i == 15);
      checks++; if (busB.brx_full !== 1'b0) begin errors++; $display("[TB] FAIL full_early write %0d: got %b want 0", i, busB.brx_full); end
      tick;
    end
    checks++; if (busB.brx_full !== 1'b1) begin errors++; $display("[TB] FAIL full_set: got %b want 1", busB.brx_full); end
    checks++; if (busB.level !== 5'd16) begin errors++; $display("[TB] FAIL full_level: got %0d want 16", busB.level); end
    checks++; if (busB.frame_count !== 5'd2) begin errors++; $display("[TB] FAIL full_fc: got %0d want 2", busB.frame_count); end
    busB.rx_axis_tdata = 8'hEE;
    busB.rx_axis_tlast = 1'b0;
    tick;
    checks++; if (busB.level !== 5'd16) begin errors++; $display("[TB] FAIL full_ignore_level: got %0d want 16", busB.level); end
    checks++; if (busB.brx_full !== 1'b1) begin errors++; $display("[TB] FAIL full_ignore_full: got %b want 1", busB.brx_full); end
    busB.brx_valid = 1'b0;
    busB.m_axis_tready = 1'b1;
    checks++; if (busB.m_axis_tdata !== 8'hA0) begin errors++; $display("[TB] FAIL full_head: got %h want a0", busB.m_axis_tdata); end
    tick;
    busB.m_axis_tready = 1'b0;
    checks++; if (busB.brx_full !== 1'b0) begin errors++; $display("[TB] FAIL full_release: got %b want 0", busB.brx_full); end
    checks++; if (busB.level !== 5'd15) begin errors++; $display("[TB] FAIL full_release_level: got %0d want 15", busB.level); end
    busB.brx_valid = 1'b1;
    busB.rx_axis_tdata = 8'h5C;
    busB.rx_axis_tlast = 1'b1;
    tick;
    busB.brx_valid = 1'b0;
    busB.rx_axis_tlast = 1'b0;
    checks++; if (busB.level !== 5'd16) begin errors++; $display("[TB] FAIL full_refill_level: got %0d want 16", busB.level); end
    checks++; if (busB.frame_count !== 5'd3) begin errors++; $display("[TB] FAIL full_refill_fc: got %0d want 3", busB.frame_count); end
    busB.m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_d = (k < 15) ? 8'hA1 + 8'(k) : 8'h5C;
      checks++; if (busB.m_axis_tvalid !== 1'b1 || busB.m_axis_tdata !== exp_d) begin errors++; $display("[TB] FAIL full_drain_data %0d: got v%b d%h want v1 d%h", k, busB.m_axis_tvalid, busB.m_axis_tdata, exp_d); end
      checks++; if (busB.m_axis_tlast !== ((k == 6) || (k == 14) || (k == 15))) begin errors++; $display("[TB] FAIL full_drain_last %0d: got %b", k, busB.m_axis_tlast); end
      tick;
    end
    busB.m_axis_tready = 1'b0;
    checks++; if (busB.level !== 5'd0) begin errors++; $display("[TB] FAIL full_drain_level: got %0d want 0", busB.level); end
    checks++; if (busB.frame_count !== 5'd0) begin errors++; $display("[TB] FAIL full_drain_fc: got %0d want 0", busB.frame_count); end
  endtask

  task automatic test_oversize;
    int   w;
    int   idx;
    int   cut_cycles;
    logic first_seen;
    logic accepted;
    w = 0;
    idx = 0;
    cut_cycles = 0;
    first_seen = 1'b0;
    busB.m_axis_tready = 1'b1;
    fork
      begin
        for (int c = 0; c < 400 && w < 40; c++) begin
          busB.brx_valid = 1'b1;
          busB.rx_axis_tdata = 8'(w);
          busB.rx_axis_tlast = (w == 39);
          accepted = (busB.brx_full === 1'b0);
          tick;
          if (accepted) w++;
        end
        busB.brx_valid = 1'b0;
        busB.rx_axis_tlast = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && idx < 40; c++) begin
          tick;
          if (busB.m_axis_tvalid === 1'b1) begin
            if (!first_seen) begin
              checks++; if (busB.brx_full !== 1'b1) begin errors++; $display("[TB] FAIL os_first_on_full: got %b want 1", busB.brx_full); end
              first_seen = 1'b1;
            end
            if (busB.frame_count === 5'd0 && busB.brx_full === 1'b0) cut_cycles++;
            checks++; if (busB.m_axis_tdata !== 8'(idx)) begin errors++; $display("[TB] FAIL os_data %0d: got %h want %h", idx, busB.m_axis_tdata, 8'(idx)); end
            checks++; if (busB.m_axis_tlast !== (idx == 39)) begin errors++; $display("[TB] FAIL os_last %0d: got %b want %b", idx, busB.m_axis_tlast, (idx == 39)); end
            idx++;
          end
        end
      end
    join
    tick;
    checks++; if (idx != 40) begin errors++; $display("[TB] FAIL os_count: got %0d want 40", idx); end
    checks++; if (cut_cycles == 0) begin errors++; $display("[TB] FAIL os_cut_through: got %0d cycles want >0", cut_cycles); end
    checks++; if (busB.level !== 5'd0) begin errors++; $display("[TB] FAIL os_level_end: got %0d want 0", busB.level); end
    for (int k = 0; k < 10; k++) begin
      busB.brx_valid = 1'b1;
      busB.rx_axis_tdata = 8'h80 + 8'(k);
      busB.rx_axis_tlast = (k == 9);
      checks++; if (busB.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL os_next_hold %0d: got %b want 0", k, busB.m_axis_tvalid); end
      tick;
    end
    busB.brx_valid = 1'b0;
    busB.rx_axis_tlast = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (busB.m_axis_tvalid !== 1'b1 || busB.m_axis_tdata !== 8'h80 + 8'(k)) begin errors++; $display("[TB] FAIL os_next_data %0d: got v%b d%h", k, busB.m_axis_tvalid, busB.m_axis_tdata); end
      checks++; if (busB.m_axis_tlast !== (k == 9)) begin errors++; $display("[TB] FAIL os_next_last %0d: got %b want %b", k, busB.m_axis_tlast, (k == 9)); end
      tick;
    end
    busB.m_axis_tready = 1'b0;
    checks++; if (busB.level !== 5'd0) begin errors++; $display("[TB] FAIL os_next_level: got %0d want 0", busB.level); end
  endtask

  task automatic test_simultaneous;
    busB.m_axis_tready = 1'b0;
    busB.brx_valid = 1'b1;
    busB.rx_axis_tdata = 8'h11;
    busB.rx_axis_tlast = 1'b1;
    tick;
    for (int k = 0; k < 14; k++) begin
      busB.rx_axis_tdata = 8'h20 + 8'(k);
      busB.rx_axis_tlast = 1'b0;
      tick;
    end
    checks++; if (busB.level !== 5'd15) begin errors++; $display("[TB] FAIL sim_pre_level: got %0d want 15", busB.level); end
    checks++; if (busB.m_axis_tdata !== 8'h11 || busB.m_axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL sim_pre_head: got d%h l%b want d11 l1", busB.m_axis_tdata, busB.m_axis_tlast); end
    busB.rx_axis_tdata = 8'h2E;
    busB.rx_axis_tlast = 1'b1;
    busB.m_axis_tready = 1'b1;
    tick;
    busB.brx_valid = 1'b0;
    busB.rx_axis_tlast = 1'b0;
    busB.m_axis_tready = 1'b0;
    checks++; if (busB.level !== 5'd15) begin errors++; $display("[TB] FAIL sim_level: got %0d want 15", busB.level); end
    checks++; if (busB.brx_full !== 1'b0) begin errors++; $display("[TB] FAIL sim_full: got %b want 0", busB.brx_full); end
    checks++; if (busB.frame_count !== 5'd1) begin errors++; $display("[TB] FAIL sim_fc: got %0d want 1", busB.frame_count); end
    busB.m_axis_tready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      checks++; if (busB.m_axis_tvalid !== 1'b1 || busB.m_axis_tdata !== 8'h20 + 8'(k)) begin errors++; $display("[TB] FAIL sim_drain_data %0d: got v%b d%h", k, busB.m_axis_tvalid, busB.m_axis_tdata); end
      checks++; if (busB.m_axis_tlast !== (k == 14)) begin errors++; $display("[TB] FAIL sim_drain_last %0d: got %b want %b", k, busB.m_axis_tlast, (k == 14)); end
      tick;
    end
    busB.m_axis_tready = 1'b0;
    checks++; if (busB.level !== 5'd0) begin errors++; $display("[TB] FAIL sim_drain_level: got %0d want 0", busB.level); end
    checks++; if (busB.frame_count !== 5'd0) begin errors++; $display("[TB] FAIL sim_drain_fc: got %0d want 0", busB.frame_count); end
  endtask

  task automatic test_async_reset;
    busA.m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      busA.brx_valid = 1'b1;
      busA.rx_axis_tdata = 8'h40 + 8'(i);
      busA.rx_axis_tlast = 1'b0;
      tick;
    end
    busA.brx_valid = 1'b0;
    checks++; if (busA.level !== 12'd20) begin errors++; $display("[TB] FAIL ar_pre_level: got %0d want 20", busA.level); end
    checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL ar_pre_tvalid: got %b want 0", busA.m_axis_tvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busA.level !== 12'd0) begin errors++; $display("[TB] FAIL ar_level: got %0d want 0", busA.level); end
    checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL ar_tvalid: got %b want 0", busA.m_axis_tvalid); end
    checks++; if (busA.brx_full !== 1'b0) begin errors++; $display("[TB] FAIL ar_full: got %b want 0", busA.brx_full); end
    checks++; if (busA.frame_count !== 12'd0) begin errors++; $display("[TB] FAIL ar_fc: got %0d want 0", busA.frame_count); end
    #2;
    rst_n = 1'b1;
    tick;
    busA.m_axis_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      busA.brx_valid = 1'b1;
      busA.rx_axis_tdata = 8'h70 + 8'(k);
      busA.rx_axis_tlast = (k == 4);
      checks++; if (busA.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL ar_new_hold %0d: got %b want 0", k, busA.m_axis_tvalid); end
      tick;
    end
    busA.brx_valid = 1'b0;
    busA.rx_axis_tlast = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (busA.m_axis_tvalid !== 1'b1 || busA.m_axis_tdata !== 8'h70 + 8'(k)) begin errors++; $display("[TB] FAIL ar_new_data %0d: got v%b d%h", k, busA.m_axis_tvalid, busA.m_axis_tdata); end
      checks++; if (busA.m_axis_tlast !== (k == 4)) begin errors++; $display("[TB] FAIL ar_new_last %0d: got %b want %b", k, busA.m_axis_tlast, (k == 4)); end
      tick;
    end
    busA.m_axis_tready = 1'b0;
    checks++; if (busA.level !== 12'd0) begin errors++; $display("[TB] FAIL ar_new_level: got %0d want 0", busA.level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    busA.brx_valid = 1'b0;
    busA.rx_axis_tdata = 8'h00;
    busA.rx_axis_tlast = 1'b0;
    busA.m_axis_tready = 1'b0;
    busB.brx_valid = 1'b0;
    busB.rx_axis_tdata = 8'h00;
    busB.rx_axis_tlast = 1'b0;
    busB.m_axis_tready = 1'b0;
    test_reset;
    $display("[TB] store-and-forward");
    test_store_forward;
    $display("[TB] back-to-back with stalls");
    test_back_to_back;
    $display("[TB] full backpressure");
    test_full_backpressure;
    $display("[TB] oversize frame");
    test_oversize;
    $display("[TB] simultaneous read/write");
    test_simultaneous;
    $display("[TB] async reset mid-frame");
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
